// File: rtl/window_line_buffer_if.sv
// Write/read stream bundle for the window line buffer.
// master = producer/consumer side, slave = the buffer itself.
interface window_line_buffer_if #(
  parameter int DATA_W = 16,
  parameter int K      = 3,
  parameter int ROWS   = 5,
  parameter int PWR    = 1,
  parameter int PRD    = 1
);
  localparam int LW = $clog2(ROWS + 1);

  logic [PWR*DATA_W-1:0]   i_data;
  logic                    i_valid;
  logic                    o_ready;
  logic [K*PRD*DATA_W-1:0] o_data;
  logic                    o_valid;
  logic                    i_ready;
  logic                    o_last;
  logic                    o_row_done;
  logic [LW-1:0]           o_level;

  modport master (
    output i_data, i_valid, i_ready,
    input  o_ready, o_data, o_valid, o_last, o_row_done, o_level
  );

  modport slave (
    input  i_data, i_valid, i_ready,
    output o_ready, o_data, o_valid, o_last, o_row_done, o_level
  );
endinterface

// File: rtl/window_line_buffer.sv
// Ring of ROWS row buffers. Rows are written PWR elements per beat; once K
// complete rows exist, a vertical K-tap window is streamed out PRD columns
// per beat. Each finished pass frees the oldest row (stride 1).
module window_line_buffer #(
  parameter int DATA_W = 16,
  parameter int CH     = 8,
  parameter int ROWS   = 5,
  parameter int K      = 3,
  parameter int PWR    = 1,
  parameter int PRD    = 1
) (
  input logic                 i_clk,
  input logic                 i_rst,
  window_line_buffer_if.slave bus
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam int LW = $clog2(ROWS + 1);

  logic [DATA_W-1:0]       mem [ROWS][CH];
  logic [RW-1:0]           wr_row, base;
  logic [CW-1:0]           wr_ch, rd_ch;
  logic [LW-1:0]           level;
  logic                    wr_go, wr_end, rd_go, rd_end;
  logic [K*PRD*DATA_W-1:0] rd_win;

  // Modular row arithmetic for a ring that need not be a power of two.
  function automatic logic [RW-1:0] row_add(input logic [RW-1:0] r, input int n);
    int s;
    s = int'(r) + n;
    if (s >= ROWS) s = s - ROWS;
    return RW'(s);
  endfunction

  // Full ring blocks writes; the unconsumed rows are never overwritten.
  assign bus.o_ready = (level < LW'(ROWS));
  assign bus.o_level = level;
  assign wr_go  = bus.i_valid && bus.o_ready && !i_rst;
  assign wr_end = wr_go && (wr_ch == CW'(CH - PWR));
  assign rd_go  = (level >= LW'(K)) && (!bus.o_valid || bus.i_ready);
  assign rd_end = rd_go && (rd_ch == CW'(CH - PRD));

  // Window mux: column j, tap t reads row base+t at channel rd_ch+j.
  for (genvar j = 0; j < PRD; j++) begin : g_col
    for (genvar t = 0; t < K; t++) begin : g_tap
      assign rd_win[(j*K+t)*DATA_W +: DATA_W] = mem[row_add(base, t)][rd_ch + CW'(j)];
    end
  end

  // Row storage; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (wr_go)
      for (int p = 0; p < PWR; p++)
        mem[wr_row][wr_ch + CW'(p)] <= bus.i_data[p*DATA_W +: DATA_W];
  end

  // Pointers, occupancy and the registered output beat.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_row         <= '0;
      wr_ch          <= '0;
      base           <= '0;
      rd_ch          <= '0;
      level          <= '0;
      bus.o_row_done <= 1'b0;
      bus.o_valid    <= 1'b0;
      bus.o_last     <= 1'b0;
      bus.o_data     <= '0;
    end else begin
      bus.o_row_done <= wr_end;
      if (wr_go) begin
        wr_ch <= wr_end ? '0 : wr_ch + CW'(PWR);
        if (wr_end) wr_row <= row_add(wr_row, 1);
      end
      if (rd_go) begin
        rd_ch <= rd_end ? '0 : rd_ch + CW'(PRD);
        if (rd_end) base <= row_add(base, 1);
      end
      // Simultaneous row fill and pass end cancel out.
      if (wr_end && !rd_end)
        level <= level + LW'(1);
      else if (rd_end && !wr_end)
        level <= level - LW'(1);
      if (rd_go) begin
        bus.o_valid <= 1'b1;
        bus.o_data  <= rd_win;
        bus.o_last  <= rd_end;
      end else if (bus.i_ready) begin
        bus.o_valid <= 1'b0;
        bus.o_last  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_window_line_buffer.sv
// Scoreboard bench: stimulus queues expected window beats, a negedge monitor
// pops and compares every beat the DUT hands over.
module tb_window_line_buffer;
  localparam int DW = 16, CH = 4, K = 3, ROWS = 4;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  window_line_buffer_if #(.DATA_W(DW), .K(K), .ROWS(ROWS), .PWR(1), .PRD(1)) bus ();

  window_line_buffer #(.DATA_W(DW), .CH(CH), .ROWS(ROWS), .K(K), .PWR(1), .PRD(1)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (bus)
  );

  typedef logic [K*DW:0] beat_t;  // {last, tap2, tap1, tap0}
  beat_t exp_q[$];
  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic beat_t win(input int a, input int b, input int c, input bit last);
    return {last, DW'(c), DW'(b), DW'(a)};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input int v);
    bus.i_valid = 1'b1;
    bus.i_data  = DW'(v);
    tick();
    bus.i_valid = 1'b0;
  endtask

  // Pass with oldest row b: column c holds {4b+c, 4(b+1)+c, 4(b+2)+c}.
  task automatic push_pass(input int b);
    for (int c = 0; c < CH; c++)
      exp_q.push_back(win(4*b + c, 4*(b+1) + c, 4*(b+2) + c, c == CH-1));
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    exp_q.delete();
    tick();
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
    exp_q.delete();
  endtask

  // Monitor: a beat transfers on the next rising edge when valid && ready.
  beat_t got_e;
  always @(negedge i_clk) begin
    if (!i_rst && bus.o_valid && bus.i_ready) begin
      if (exp_q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_beat: got 0x%0h want none", {bus.o_last, bus.o_data});
      end else begin
        got_e = exp_q.pop_front();
        chk("beat", {bus.o_last, bus.o_data}, got_e);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_ready = 1'b0;

    // Reset state
    do_reset();
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_level", bus.o_level, 0);
    chk("rst_ready", bus.o_ready, 1);
    chk("rst_data",  bus.o_data, 0);

    // Three rows, free-running consumer
    bus.i_ready = 1'b1;
    push_pass(0);
    for (int w = 0; w < 12; w++) begin
      wr(w);
      chk("row_done", bus.o_row_done, (w % 4) == 3);
    end
    chk("lvl_3rows", bus.o_level, 3);
    drain(40);
    chk("lvl_after_pass", bus.o_level, 2);
    chk("valid_drop", bus.o_valid, 0);

    // Fill the ring with a stalled consumer
    do_reset();
    bus.i_ready = 1'b0;
    for (int w = 0; w < 16; w++) wr(w);
    chk("full_level", bus.o_level, 4);
    chk("full_ready", bus.o_ready, 0);
    wr(99);
    chk("ignored_level", bus.o_level, 4);
    chk("stall_valid", bus.o_valid, 1);
    chk("stall_data", bus.o_data, {16'd8, 16'd4, 16'd0});

    // Hold under backpressure, then release
    repeat (3) begin
      tick();
      chk("hold_data",  bus.o_data, {16'd8, 16'd4, 16'd0});
      chk("hold_valid", bus.o_valid, 1);
      chk("hold_last",  bus.o_last, 0);
    end
    push_pass(0);
    push_pass(1);
    bus.i_ready = 1'b1;
    tick();
    chk("release_next", bus.o_data, {16'd9, 16'd5, 16'd1});
    drain(40);
    chk("lvl_after_two", bus.o_level, 2);

    // Streaming 6 rows: ring and base wrap, level steady on overlap
    do_reset();
    bus.i_ready = 1'b1;
    for (int b = 0; b < 4; b++) push_pass(b);
    for (int w = 0; w < 24; w++) begin
      wr(w);
      if (w == 11 || w == 15 || w == 19 || w == 23)
        chk("stream_level", bus.o_level, 3);
    end
    drain(40);
    chk("stream_end_level", bus.o_level, 2);

    // Reset mid-row with a simultaneous write, then restart
    do_reset();
    bus.i_ready = 1'b1;
    for (int w = 0; w < 6; w++) wr(w);
    bus.i_valid = 1'b1;
    bus.i_data  = DW'(77);
    i_rst = 1'b1;
    tick();
    bus.i_valid = 1'b0;
    chk("midrst_level", bus.o_level, 0);
    chk("midrst_valid", bus.o_valid, 0);
    i_rst = 1'b0;
    push_pass(0);
    for (int w = 0; w < 12; w++) wr(w);
    drain(40);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
